// File: rtl/image_stream_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : image_stream_feeder_if
//  Brief    : Pixel stream valid/ready bundle between feeder and network.
//  Revision : 1.0 - initial release
// ============================================================================
interface image_stream_feeder_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] m_axis_data;
   logic                  m_axis_valid;
   logic                  m_axis_ready;

   modport master (
      output m_axis_data,
      output m_axis_valid,
      input  m_axis_ready
   );

   modport slave (
      input  m_axis_data,
      input  m_axis_valid,
      output m_axis_ready
   );
endinterface
`default_nettype wire

// File: rtl/image_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : image_stream_feeder
//  Brief    : Frame buffer that streams one test image to the network and
//             scores the returned class against the stored label.
//  Revision : 1.0 - initial release
// ============================================================================
module image_stream_feeder #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_PIXELS = 784,
   parameter int ADDR_W     = 10,
   parameter int CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    start,
   input  logic                    clear_stats,
   image_stream_feeder_if.master   axis,
   input  logic                    result_valid,
   input  logic [31:0]             result_data,
   output logic                    busy,
   output logic                    done,
   output logic                    match,
   output logic [DATA_WIDTH-1:0]   label,
   output logic [CNT_W-1:0]        right_cnt,
   output logic [CNT_W-1:0]        total_cnt
);

   localparam logic [ADDR_W-1:0] PIX_END = ADDR_W'(NUM_PIXELS);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PRIME    = 3'd1,
      ST_STREAM   = 3'd2,
      ST_WAIT_RES = 3'd3,
      ST_CHECK    = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0]  m_axis_data_q, m_axis_data_d;
   logic                   m_axis_valid_q, m_axis_valid_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   match_q, match_d;
   logic [DATA_WIDTH-1:0]  label_q, label_d;
   logic [CNT_W-1:0]       right_cnt_q, right_cnt_d;
   logic [CNT_W-1:0]       total_cnt_q, total_cnt_d;
   logic [DATA_WIDTH-1:0]  label_store_q, label_store_d;

   logic [DATA_WIDTH-1:0]  pix_mem [0:NUM_PIXELS-1];

   logic                   wr_ok;
   logic                   pix_wr;
   logic                   label_wr;
   logic                   result_match;
   logic                   beat;

   assign wr_ok        = wr_en && (state_q == ST_IDLE);
   assign pix_wr       = wr_ok && (wr_addr < PIX_END);
   assign label_wr     = wr_ok && (wr_addr == PIX_END);
   assign result_match = (result_data[DATA_WIDTH-1:0] == label_q);
   assign beat         = m_axis_valid_q && axis.m_axis_ready;

   generate
      if (DATA_WIDTH < 32) begin : g_result_hi
         logic result_hi_unused;
         assign result_hi_unused = ^result_data[31:DATA_WIDTH];
      end
   endgenerate

   // Buffer storage deliberately has no reset so a frame survives rst.
   always_ff @(posedge clk) begin
      if (pix_wr) begin
         pix_mem[wr_addr] <= wr_data;
      end
      label_store_q <= label_store_d;
   end

   always_comb begin
      label_store_d = label_store_q;
      if (label_wr) begin
         label_store_d = wr_data;
      end
   end

   always_comb begin
      state_d        = state_q;
      rd_ptr_d       = rd_ptr_q;
      m_axis_data_d  = m_axis_data_q;
      m_axis_valid_d = m_axis_valid_q;
      done_d         = 1'b0;
      match_d        = match_q;
      label_d        = label_q;
      right_cnt_d    = right_cnt_q;
      total_cnt_d    = total_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_PRIME;
            end
         end
         ST_PRIME: begin
            label_d  = label_store_q;
            rd_ptr_d = '0;
            state_d  = ST_STREAM;
         end
         ST_STREAM: begin
            // The output register is refilled on the same edge it drains,
            // which keeps back-to-back beats free of bubbles.
            if (beat && (rd_ptr_q == PIX_END)) begin
               m_axis_valid_d = 1'b0;
               state_d        = ST_WAIT_RES;
            end else if ((!m_axis_valid_q || axis.m_axis_ready) && (rd_ptr_q != PIX_END)) begin
               m_axis_data_d  = pix_mem[rd_ptr_q];
               m_axis_valid_d = 1'b1;
               rd_ptr_d       = rd_ptr_q + ADDR_W'(1);
            end
         end
         ST_WAIT_RES: begin
            if (result_valid) begin
               state_d = ST_CHECK;
               done_d  = 1'b1;
               match_d = result_match;
               if (total_cnt_q != CNT_MAX) begin
                  total_cnt_d = total_cnt_q + CNT_W'(1);
               end
               if (result_match && (right_cnt_q != CNT_MAX)) begin
                  right_cnt_d = right_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_CHECK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (clear_stats) begin
         right_cnt_d = '0;
         total_cnt_d = '0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         rd_ptr_q       <= '0;
         m_axis_data_q  <= '0;
         m_axis_valid_q <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         match_q        <= 1'b0;
         label_q        <= '0;
         right_cnt_q    <= '0;
         total_cnt_q    <= '0;
      end else begin
         state_q        <= state_d;
         rd_ptr_q       <= rd_ptr_d;
         m_axis_data_q  <= m_axis_data_d;
         m_axis_valid_q <= m_axis_valid_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         match_q        <= match_d;
         label_q        <= label_d;
         right_cnt_q    <= right_cnt_d;
         total_cnt_q    <= total_cnt_d;
      end
   end

   assign axis.m_axis_data  = m_axis_data_q;
   assign axis.m_axis_valid = m_axis_valid_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign match             = match_q;
   assign label             = label_q;
   assign right_cnt         = right_cnt_q;
   assign total_cnt         = total_cnt_q;

endmodule
`default_nettype wire
